core_inst_seq: RTL and testbench
================================

// Module: core_inst_seq
// PURPOSE
//  Hardware instruction sequencer for the 2D systolic core; replaces hand-driven bench stimulus.
//  On start, runs a full conv layer as len_kij kernel passes, each pass doing:
//    weight load -> activation stream/execute -> psum drain to pmem.
//  Then runs an accumulate pass over pmem for every output pixel.
//  Drives the core's 34-bit inst bus; sits between the host/top controller and core.
// PARAMETERS
//  row       8   PE rows (activation lanes)
//  col       8   PE columns; also weight words per kernel position
//  in_w      6   input feature-map width (square); len_nij = in_w*in_w
//  k_w       3   kernel width (square); len_kij = k_w*k_w; o_w = in_w-k_w+1
//  addr_w    11  xmem/pmem address width
//  X_BASE    0   xmem base of activations (len_nij words)
//  W_BASE    64  xmem base of weights; kernel position k at W_BASE+k*col
//  P_BASE    0   pmem base; kernel position k psums at P_BASE+k*len_nij
//  LOAD_GAP  8   idle cycles after weight load before activation stream
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   one-cycle request; sampled only in IDLE
//  ofifo_valid  in   1   core output FIFO has a word
//  inst         out  34  {acc,CEN_pmem,WEN_pmem,A_pmem[10:0],CEN_xmem,WEN_xmem,A_xmem[10:0],
//                         ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}; registered
//  busy         out  1   high from cycle after accepted start until done
//  done         out  1   one-cycle pulse on completion
//  kij          out  4   current kernel position (0..len_kij-1)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; inst=IDLE_WORD 34'h1_800C_0000; busy=0, done=0, kij=0.
//  IDLE_WORD: both CEN/WEN high; all other bits 0.
//  Memory enables are active-low; reads use CEN=0,WEN=1; writes use CEN=0,WEN=0.
//  States / transitions:
//   IDLE  -start-> W_RD
//   W_RD: col xmem reads at W_BASE+kij*col+i; l0_wr trails each read by 1 cycle (col+1 cycles) -> W_LD
//   W_LD: col cycles of l0_rd=1,load=1 -> GAP
//   GAP: LOAD_GAP cycles of IDLE_WORD -> X_RD
//   X_RD: len_nij xmem reads at X_BASE+n, l0_wr skewed 1 cycle (len_nij+1 cycles) -> X_EX
//   X_EX: len_nij cycles of l0_rd=1,execute=1 -> DRAIN
//   DRAIN: per word, ofifo_rd=1 only in cycles with ofifo_valid=1;
//          pmem write at P_BASE+kij*len_nij+n issued the following cycle.
//          After len_nij writes: if kij==len_kij-1 -> ACC, else kij++ and -> W_RD.
//   ACC: for o in 0..o_w*o_w-1, k in 0..len_kij-1: pmem read, acc=1.
//        Address = P_BASE + k*len_nij + (o/o_w + k/k_w)*in_w + (o%o_w + k%k_w).
//        Row/col indices come from nested counters; no dividers.
//        After o_w*o_w*len_kij cycles -> DONE.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Handshake / boundaries:
//   start while busy is ignored (no queuing).
//   DRAIN with ofifo_valid=0 stalls; inst=IDLE_WORD, counters hold.
//   Address counters reset at every phase entry; no wrap past phase length.
//   inst changes only on clk rising edge; one cycle latency from state to inst.
//   Reset mid-operation aborts immediately; no partial pmem cleanup.
// CONFIGURATION
//  SEQ_PAUSE_EN defined:
//   adds input pause (1b); while pause=1, FSM and all counters hold.
//   inst=IDLE_WORD for those cycles; resumes exactly where it stopped.
//   A DRAIN pmem write already pending is still issued on the first pause cycle.
//  SEQ_PAUSE_EN undefined: port absent; sequencer never pauses except DRAIN stalls.
// STRUCTURE
//  Package core_seq_pkg holds:
//   state enum, INST_* bit-position localparams, IDLE_WORD constant,
//   and a function packing fields into the 34-bit word.
//  One sub-module, seq_addr_gen: nested o-row/o-col/k-row/k-col counters producing the ACC address.
//  All other logic lives in one FSM + counter process.
// TESTING
//  1. Reset held low 10 cycles -> inst==34'h1_800C_0000, busy=0; release, no start -> inst unchanged.
//  2. start, ofifo_valid=1 always -> W_RD addresses 64..71, l0_wr first seen 1 cycle after A_xmem=64;
//     8 load cycles; kij increments 0..8.
//  3. DRAIN with ofifo_valid toggling 1/0 -> exactly 36 pmem writes per kij;
//     kij=2 addresses 72..107; no write without prior ofifo_rd.
//  4. ACC pass -> 144 acc=1 reads. Spot checks:
//     o=0,k=0 -> 0; o=5,k=4 -> 4*36+(1+1)*6+(1+1)=158; o=15,k=8 -> 288+5*6+5=323.
//     Then done 1 cycle, busy=0.
//  5. reset low during X_EX of kij=3 -> next cycle inst==IDLE_WORD, kij=0; new start runs full layer.
//  6. start pulsed while busy -> ignored.
//     (SEQ_PAUSE_EN) pause=1 for 5 cycles in X_RD -> 5 IDLE_WORDs, then A_xmem resumes at next address.

Source files
------------

// File: rtl/core_inst_seq_pkg.sv
// core_seq_pkg: shared types and constants for the core instruction sequencer.
//   state_t        sequencer phases
//   INST_*         bit positions inside the 34-bit core instruction word
//   IDLE_WORD      instruction with both memories disabled and no strobes
//   inst_fields_t  decoded view of one instruction; pack_inst() builds the word
package core_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_RD, S_W_LD, S_GAP, S_X_RD, S_X_EX, S_DRAIN, S_ACC, S_DONE
  } state_t;

  localparam int unsigned INST_W        = 34;
  localparam int unsigned A_W           = 11;
  localparam int unsigned INST_LOAD     = 0;
  localparam int unsigned INST_EXECUTE  = 1;
  localparam int unsigned INST_L0_WR    = 2;
  localparam int unsigned INST_L0_RD    = 3;
  localparam int unsigned INST_IFIFO_RD = 4;
  localparam int unsigned INST_IFIFO_WR = 5;
  localparam int unsigned INST_OFIFO_RD = 6;
  localparam int unsigned INST_A_XMEM   = 7;
  localparam int unsigned INST_WEN_XMEM = 18;
  localparam int unsigned INST_CEN_XMEM = 19;
  localparam int unsigned INST_A_PMEM   = 20;
  localparam int unsigned INST_WEN_PMEM = 31;
  localparam int unsigned INST_CEN_PMEM = 32;
  localparam int unsigned INST_ACC      = 33;

  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef struct packed {
    logic           acc;
    logic           pmem_rd;
    logic           pmem_wr;
    logic [A_W-1:0] a_pmem;
    logic           xmem_rd;
    logic [A_W-1:0] a_xmem;
    logic           ofifo_rd;
    logic           l0_rd;
    logic           l0_wr;
    logic           execute;
    logic           load;
  } inst_fields_t;

  // Address fields stay zero unless the matching memory is enabled, so an
  // all-zero field set packs to exactly IDLE_WORD.
  function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
    logic [INST_W-1:0] w;
    w = IDLE_WORD;
    w[INST_ACC]      = f.acc;
    w[INST_OFIFO_RD] = f.ofifo_rd;
    w[INST_L0_RD]    = f.l0_rd;
    w[INST_L0_WR]    = f.l0_wr;
    w[INST_EXECUTE]  = f.execute;
    w[INST_LOAD]     = f.load;
    if (f.pmem_rd || f.pmem_wr) begin
      w[INST_CEN_PMEM]           = 1'b0;
      w[INST_WEN_PMEM]           = ~f.pmem_wr;
      w[INST_A_PMEM +: A_W]      = f.a_pmem;
    end
    if (f.xmem_rd) begin
      w[INST_CEN_XMEM]           = 1'b0;
      w[INST_A_XMEM +: A_W]      = f.a_xmem;
    end
    return w;
  endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: host/core-facing signals of the sequencer.
//   start, ofifo_valid (and pause when SEQ_PAUSE_EN is defined) into the sequencer;
//   inst[33:0], busy, done, kij[3:0] out of it.
//   slave modport: sequencer side; master modport: host/bench side.
interface core_inst_seq_if;
  logic        start;
  logic        ofifo_valid;
`ifdef SEQ_PAUSE_EN
  logic        pause;
`endif
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

`ifdef SEQ_PAUSE_EN
  modport slave  (input start, ofifo_valid, pause, output inst, busy, done, kij);
  modport master (output start, ofifo_valid, pause, input inst, busy, done, kij);
`else
  modport slave  (input start, ofifo_valid, output inst, busy, done, kij);
  modport master (output start, ofifo_valid, input inst, busy, done, kij);
`endif
endinterface

// File: rtl/core_inst_seq_addr_gen.sv
// seq_addr_gen: pmem read address generator for the accumulate pass.
//   clk, reset (async active-low), clr_i (zero all counters), adv_i (step once)
//   addr_o = P_BASE + k*len_nij + (o_row+k_row)*in_w + (o_col+k_col)
//   last_o high while the counters sit on the final (o, k) pair
// Kernel position is the inner loop; o_row/o_col/k_row/k_col are nested
// counters so no division is needed.
module seq_addr_gen #(
  parameter int unsigned in_w   = 6,
  parameter int unsigned k_w    = 3,
  parameter int unsigned P_BASE = 0,
  parameter int unsigned addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [addr_w-1:0] addr_o,
  output logic              last_o
);
  localparam int unsigned O_W     = in_w - k_w + 1;
  localparam int unsigned LEN_NIJ = in_w * in_w;
  localparam logic [7:0]  K_MAX   = 8'(k_w - 1);
  localparam logic [7:0]  O_MAX   = 8'(O_W - 1);
  localparam logic [7:0]  KI_MAX  = 8'(k_w * k_w - 1);

  logic [7:0]  kc_q, kr_q, oc_q, or_q, kidx_q;
  logic [31:0] addr_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kc_q <= '0; kr_q <= '0; oc_q <= '0; or_q <= '0; kidx_q <= '0;
    end else if (clr_i) begin
      kc_q <= '0; kr_q <= '0; oc_q <= '0; or_q <= '0; kidx_q <= '0;
    end else if (adv_i) begin
      kidx_q <= (kidx_q == KI_MAX) ? '0 : kidx_q + 8'd1;
      if (kc_q == K_MAX) begin
        kc_q <= '0;
        if (kr_q == K_MAX) begin
          kr_q <= '0;
          if (oc_q == O_MAX) begin
            oc_q <= '0;
            if (or_q != O_MAX) or_q <= or_q + 8'd1;
          end else begin
            oc_q <= oc_q + 8'd1;
          end
        end else begin
          kr_q <= kr_q + 8'd1;
        end
      end else begin
        kc_q <= kc_q + 8'd1;
      end
    end
  end

  always_comb begin
    addr_sum = P_BASE + 32'(kidx_q) * LEN_NIJ + (32'(or_q) + 32'(kr_q)) * in_w
             + 32'(oc_q) + 32'(kc_q);
    addr_o   = addr_sum[addr_w-1:0];
    last_o   = (kc_q == K_MAX) && (kr_q == K_MAX) && (oc_q == O_MAX) && (or_q == O_MAX);
  end

endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer running a full conv layer on the systolic core.
//   clk, reset (async active-low)
//   bus (core_inst_seq_if.slave): start, ofifo_valid in; inst[33:0], busy, done, kij out
// Per kernel position: weight read/load, gap, activation read/execute, psum drain;
// then one accumulate pass over pmem. All outputs are registered.
// Optional feature macro SEQ_PAUSE_EN adds bus.pause, which freezes the sequencer.
module core_inst_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned in_w     = 6,
  parameter int unsigned k_w      = 3,
  parameter int unsigned addr_w   = 11,
  parameter int unsigned X_BASE   = 0,
  parameter int unsigned W_BASE   = 64,
  parameter int unsigned P_BASE   = 0,
  parameter int unsigned LOAD_GAP = 8
) (
  input  logic             clk,
  input  logic             reset,
  core_inst_seq_if.slave   bus
);
  localparam int unsigned LEN_NIJ = in_w * in_w;
  localparam int unsigned LEN_KIJ = k_w * k_w;
  localparam logic [15:0] COL_C   = 16'(col);
  localparam logic [15:0] NIJ_C   = 16'(LEN_NIJ);
  localparam logic [15:0] GAP_C   = 16'(LOAD_GAP);
  localparam logic [3:0]  KLAST_C = 4'(LEN_KIJ - 1);

  // Each xmem activation word carries one value per row lane; the lane count
  // does not affect sequencing, so a zero-lane array simply has nothing to build.
  if (row == 0) begin : g_no_lanes
  end

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, wr_q, wr_d, wr_nx;
  logic              pend_q, pend_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              hold;
  logic [31:0]       w_sum, x_sum, p_sum;
  logic [addr_w-1:0] acc_addr;
  logic              acc_last;
  inst_fields_t      f;

`ifdef SEQ_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  seq_addr_gen #(.in_w(in_w), .k_w(k_w), .P_BASE(P_BASE), .addr_w(addr_w)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != S_ACC),
    .adv_i  ((state_q == S_ACC) && !hold),
    .addr_o (acc_addr),
    .last_o (acc_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    kij_d   = kij_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    f       = '0;
    w_sum   = W_BASE + 32'(kij_q) * col + 32'(cnt_q);
    x_sum   = X_BASE + 32'(cnt_q);
    p_sum   = P_BASE + 32'(kij_q) * LEN_NIJ + 32'(wr_q);
    wr_nx   = wr_q + {15'd0, pend_q};

    if (hold) begin
      // A drain write already owed to pmem still goes out while frozen.
      if (state_q == S_DRAIN && pend_q) begin
        f.pmem_wr = 1'b1;
        f.a_pmem  = A_W'(p_sum[addr_w-1:0]);
        wr_d      = wr_nx;
        pend_d    = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          state_d = S_W_RD; cnt_d = '0; kij_d = '0; busy_d = 1'b1;
        end
        S_W_RD: begin
          if (cnt_q < COL_C) begin f.xmem_rd = 1'b1; f.a_xmem = A_W'(w_sum[addr_w-1:0]); end
          f.l0_wr = (cnt_q != '0);
          if (cnt_q == COL_C) begin state_d = S_W_LD; cnt_d = '0; end
          else cnt_d = cnt_q + 16'd1;
        end
        S_W_LD: begin
          f.l0_rd = 1'b1; f.load = 1'b1;
          if (cnt_q == COL_C - 16'd1) begin state_d = S_GAP; cnt_d = '0; end
          else cnt_d = cnt_q + 16'd1;
        end
        S_GAP: begin
          if (cnt_q + 16'd1 >= GAP_C) begin state_d = S_X_RD; cnt_d = '0; end
          else cnt_d = cnt_q + 16'd1;
        end
        S_X_RD: begin
          if (cnt_q < NIJ_C) begin f.xmem_rd = 1'b1; f.a_xmem = A_W'(x_sum[addr_w-1:0]); end
          f.l0_wr = (cnt_q != '0);
          if (cnt_q == NIJ_C) begin state_d = S_X_EX; cnt_d = '0; end
          else cnt_d = cnt_q + 16'd1;
        end
        S_X_EX: begin
          f.l0_rd = 1'b1; f.execute = 1'b1;
          if (cnt_q == NIJ_C - 16'd1) begin
            state_d = S_DRAIN; cnt_d = '0; wr_d = '0; pend_d = 1'b0;
          end else cnt_d = cnt_q + 16'd1;
        end
        S_DRAIN: begin
          // cnt counts ofifo reads; wr counts pmem writes, each one cycle behind its read.
          if (pend_q) begin f.pmem_wr = 1'b1; f.a_pmem = A_W'(p_sum[addr_w-1:0]); end
          wr_d   = wr_nx;
          pend_d = 1'b0;
          if (wr_nx == NIJ_C) begin
            cnt_d = '0;
            if (kij_q == KLAST_C) state_d = S_ACC;
            else begin kij_d = kij_q + 4'd1; state_d = S_W_RD; end
          end else if (bus.ofifo_valid && cnt_q < NIJ_C) begin
            f.ofifo_rd = 1'b1; cnt_d = cnt_q + 16'd1; pend_d = 1'b1;
          end
        end
        S_ACC: begin
          f.acc = 1'b1; f.pmem_rd = 1'b1; f.a_pmem = A_W'(acc_addr);
          if (acc_last) begin state_d = S_DONE; busy_d = 1'b0; done_d = 1'b1; end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    inst_d = pack_inst(f);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      pend_q  <= 1'b0;
      kij_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      kij_q   <= kij_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.kij  = kij_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: scoreboards of expected xmem, pmem-write and
// accumulate addresses are filled when a layer is started and popped as the
// instruction word shows each access.
module tb_core_inst_seq;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  core_inst_seq_if bus();

  core_inst_seq #(
    .row(8), .col(8), .in_w(6), .k_w(3), .addr_w(11),
    .X_BASE(0), .W_BASE(64), .P_BASE(0), .LOAD_GAP(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.inst !== IDLE_W) begin errors++; $display("FAIL reset_inst got %h expected %h", bus.inst, IDLE_W); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
    checks++; if (bus.kij !== 4'd0) begin errors++; $display("FAIL reset_kij got %0d expected 0", bus.kij); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.inst !== IDLE_W) begin errors++; $display("FAIL idle_inst got %h expected %h", bus.inst, IDLE_W); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_full_layer(input bit toggle, input bit extra_start, input string name);
    int xq[$];
    int pq[$];
    int aq[$];
    int wr_per_k[9];
    int ld_per_k[9];
    int spot[3];
    int acc_n, c64, l0_first, done_cyc, outstanding, kij_prev, exp_v, xa, pa;
    bit done_seen;
    logic [33:0] w;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) xq.push_back(64 + 8 * k + i);
      for (int n = 0; n < 36; n++) xq.push_back(n);
      for (int n = 0; n < 36; n++) pq.push_back(36 * k + n);
      wr_per_k[k] = 0; ld_per_k[k] = 0;
    end
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 9; k++)
        aq.push_back(36 * k + (o / 4 + k / 3) * 6 + (o % 4) + (k % 3));
    acc_n = 0; c64 = -1; l0_first = -1; done_cyc = 0; outstanding = 0; kij_prev = 0;
    done_seen = 1'b0; spot[0] = -1; spot[1] = -1; spot[2] = -1;

    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_pre got %b expected 0", name, bus.busy); end
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy_run got %b expected 1", name, bus.busy); end

    for (int cyc = 0; cyc < 6000 && !(done_seen && cyc > done_cyc + 2); cyc++) begin
      @(negedge clk);
      w  = bus.inst;
      xa = int'(w[17:7]);
      pa = int'(w[30:20]);
      if (w[6]) begin
        checks++; if (bus.ofifo_valid !== 1'b1) begin errors++; $display("FAIL %s ofifo_rd_valid got %b expected 1", name, bus.ofifo_valid); end
      end
      if (w[32] == 1'b0 && w[31] == 1'b0) begin
        checks++; if (outstanding <= 0) begin errors++; $display("FAIL %s write_no_rd got %0d expected >0", name, outstanding); end
        else outstanding--;
        exp_v = (pq.size() > 0) ? pq.pop_front() : -1;
        checks++; if (pa != exp_v) begin errors++; $display("FAIL %s pmem_wr_addr got %0d expected %0d", name, pa, exp_v); end
        if (pa < 324) wr_per_k[pa / 36]++;
      end
      if (w[6]) outstanding++;
      if (w[19] == 1'b0 && w[18] == 1'b1) begin
        exp_v = (xq.size() > 0) ? xq.pop_front() : -1;
        checks++; if (xa != exp_v) begin errors++; $display("FAIL %s xmem_addr got %0d expected %0d", name, xa, exp_v); end
        if (xa == 64 && c64 < 0) c64 = cyc;
      end
      if (w[2] && l0_first < 0) l0_first = cyc;
      if (w[0] && bus.kij < 9) ld_per_k[bus.kij]++;
      if (w[33]) begin
        checks++; if (w[32] !== 1'b0 || w[31] !== 1'b1) begin errors++; $display("FAIL %s acc_is_read got %b%b expected 01", name, w[32], w[31]); end
        exp_v = (aq.size() > 0) ? aq.pop_front() : -1;
        checks++; if (pa != exp_v) begin errors++; $display("FAIL %s acc_addr got %0d expected %0d", name, pa, exp_v); end
        if (acc_n == 0) spot[0] = pa;
        if (acc_n == 49) spot[1] = pa;
        if (acc_n == 143) spot[2] = pa;
        acc_n++;
      end
      if (int'(bus.kij) != kij_prev) begin
        checks++; if (int'(bus.kij) != kij_prev + 1) begin errors++; $display("FAIL %s kij_step got %0d expected %0d", name, bus.kij, kij_prev + 1); end
        kij_prev = int'(bus.kij);
      end
      if (bus.done) begin
        checks++; if (done_seen) begin errors++; $display("FAIL %s done_extra got 1 expected 0", name); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s done_busy got %b expected 0", name, bus.busy); end
        if (!done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
      end
      bus.start = (extra_start && cyc == 100) ? 1'b1 : 1'b0;
      bus.ofifo_valid = toggle ? ~bus.ofifo_valid : 1'b1;
    end
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b1;

    checks++; if (!done_seen) begin errors++; $display("FAIL %s done_timeout got 0 expected 1", name); end
    checks++; if (acc_n != 144) begin errors++; $display("FAIL %s acc_count got %0d expected 144", name, acc_n); end
    checks++; if (spot[0] != 0) begin errors++; $display("FAIL %s acc_o0k0 got %0d expected 0", name, spot[0]); end
    checks++; if (spot[1] != 158) begin errors++; $display("FAIL %s acc_o5k4 got %0d expected 158", name, spot[1]); end
    checks++; if (spot[2] != 323) begin errors++; $display("FAIL %s acc_o15k8 got %0d expected 323", name, spot[2]); end
    checks++; if (xq.size() + pq.size() + aq.size() != 0) begin errors++; $display("FAIL %s scoreboard_left got %0d expected 0", name, xq.size() + pq.size() + aq.size()); end
    checks++; if (l0_first != c64 + 1) begin errors++; $display("FAIL %s l0_wr_skew got %0d expected %0d", name, l0_first, c64 + 1); end
    checks++; if (kij_prev != 8) begin errors++; $display("FAIL %s kij_final got %0d expected 8", name, kij_prev); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (wr_per_k[k] != 36) begin errors++; $display("FAIL %s writes_k%0d got %0d expected 36", name, k, wr_per_k[k]); end
      checks++; if (ld_per_k[k] != 8) begin errors++; $display("FAIL %s loads_k%0d got %0d expected 8", name, k, ld_per_k[k]); end
    end
  endtask

  task automatic test_back_to_back_start();
    test_full_layer(1'b1, 1'b1, "busy_start");
  endtask

  task automatic test_reset_mid_op();
    bit found;
    found = 1'b0;
    bus.ofifo_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (bus.inst[1] && bus.kij == 4'd3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach got 0 expected 1"); end
    reset = 1'b0;
    #1;
    checks++; if (bus.inst !== IDLE_W) begin errors++; $display("FAIL rst_mid_inst got %h expected %h", bus.inst, IDLE_W); end
    checks++; if (bus.kij !== 4'd0) begin errors++; $display("FAIL rst_mid_kij got %0d expected 0", bus.kij); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.inst !== IDLE_W) begin errors++; $display("FAIL rst_mid_next got %h expected %h", bus.inst, IDLE_W); end
    reset = 1'b1;
    @(negedge clk);
    test_full_layer(1'b0, 1'b0, "after_reset");
  endtask

`ifdef SEQ_PAUSE_EN
  task automatic test_pause();
    bit found;
    found = 1'b0;
    bus.ofifo_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.inst[19] == 1'b0 && bus.inst[18] == 1'b1 && bus.inst[17:7] == 11'd10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL pause_reach got 0 expected 1"); end
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.inst !== IDLE_W) begin errors++; $display("FAIL pause_idle%0d got %h expected %h", i, bus.inst, IDLE_W); end
    end
    bus.pause = 1'b0;
    @(negedge clk);
    checks++; if (bus.inst[19:7] !== {2'b01, 11'd11}) begin errors++; $display("FAIL pause_resume got %h expected %h", bus.inst[19:7], {2'b01, 11'd11}); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b1;
`ifdef SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_full_layer(1'b0, 1'b0, "steady");
    test_full_layer(1'b1, 1'b0, "toggle");
    test_back_to_back_start();
    test_reset_mid_op();
`ifdef SEQ_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
